// File: rtl/match_ctrl.sv
// Match sequencer for head-soccer: gates ball physics, detects goals,
// keeps both scores and the match clock, and reports the winner.
module match_ctrl #(
    parameter int KICKOFF_FRAMES = 120,
    parameter int GOAL_FRAMES    = 90,
    parameter int FRAMES_PER_SEC = 60,
    parameter int MATCH_SECONDS  = 90,
    parameter int WIN_SCORE      = 5,
    parameter int GOAL_X_L       = 8,
    parameter int GOAL_X_R       = 631,
    parameter int GOAL_Y_TOP     = 360
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    output logic       BallRst,
    output logic       Freeze,
    output logic [3:0] Score1,
    output logic [3:0] Score2,
    output logic [7:0] TimeLeft,
    output logic [2:0] State,
    output logic [1:0] Winner,
    output logic       GoalFlash
);

    localparam int HOLD_MAX = (KICKOFF_FRAMES > GOAL_FRAMES) ? KICKOFF_FRAMES : GOAL_FRAMES;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int SW = $clog2(FRAMES_PER_SEC + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KICKOFF   = 3'd1,
        S_PLAY      = 3'd2,
        S_GOAL      = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          start_q_reg;
    logic [HW-1:0] hold_cnt_reg;
    logic [SW-1:0] sub_cnt_reg;

    logic start_rise;
    logic in_play;
    logic goal_l;
    logic goal_r;
    logic goal;
    logic sec_wrap;
    logic hold_zero;
    logic match_done;
    logic restart;
    logic [10:0] ball_right;

    assign start_rise = Start & ~start_q_reg;
    assign in_play    = (state_reg == S_PLAY);
    assign hold_zero  = (hold_cnt_reg == '0);
    assign sec_wrap   = in_play && (sub_cnt_reg == SW'(FRAMES_PER_SEC - 1));
    assign restart    = (state_reg == S_GAME_OVER) && start_rise;

    // 11-bit compare so that BallX+BallS cannot wrap past the right goal line
    assign ball_right = {1'b0, BallX} + {1'b0, BallS};
    assign goal_l     = ({1'b0, BallX} <= 11'(GOAL_X_L)) && ({1'b0, BallY} >= 11'(GOAL_Y_TOP));
    assign goal_r     = (ball_right >= 11'(GOAL_X_R)) && ({1'b0, BallY} >= 11'(GOAL_Y_TOP));
    assign goal       = in_play && (goal_l || goal_r);

    assign match_done = (Score1 >= 4'(WIN_SCORE)) || (Score2 >= 4'(WIN_SCORE)) ||
                        (TimeLeft == 8'd0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (start_rise) state_next = S_KICKOFF;
            S_KICKOFF:   if (hold_zero) state_next = S_PLAY;
            S_PLAY: begin
                // A goal beats the timeout; the clock still ticks that cycle
                if (goal)
                    state_next = S_GOAL;
                else if (sec_wrap && TimeLeft == 8'd1)
                    state_next = S_GAME_OVER;
            end
            S_GOAL:      if (hold_zero) state_next = match_done ? S_GAME_OVER : S_KICKOFF;
            S_GAME_OVER: if (start_rise) state_next = S_KICKOFF;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= S_IDLE;
            start_q_reg  <= 1'b0;
            hold_cnt_reg <= '0;
            sub_cnt_reg  <= '0;
            BallRst      <= 1'b1;
            Freeze       <= 1'b1;
            GoalFlash    <= 1'b0;
            Score1       <= 4'd0;
            Score2       <= 4'd0;
            TimeLeft     <= 8'(MATCH_SECONDS);
            Winner       <= 2'b00;
        end else begin
            start_q_reg <= Start;
            state_reg   <= state_next;
            BallRst     <= (state_next != S_PLAY);
            Freeze      <= (state_next != S_PLAY);
            GoalFlash   <= (state_next == S_GOAL);

            if (state_next == S_KICKOFF && state_reg != S_KICKOFF)
                hold_cnt_reg <= HW'(KICKOFF_FRAMES - 1);
            else if (state_next == S_GOAL && state_reg != S_GOAL)
                hold_cnt_reg <= HW'(GOAL_FRAMES - 1);
            else if ((state_reg == S_KICKOFF || state_reg == S_GOAL) && !hold_zero)
                hold_cnt_reg <= hold_cnt_reg - HW'(1);

            if (restart)
                sub_cnt_reg <= '0;
            else if (in_play)
                sub_cnt_reg <= sec_wrap ? '0 : sub_cnt_reg + SW'(1);

            if (restart)
                TimeLeft <= 8'(MATCH_SECONDS);
            else if (sec_wrap && TimeLeft != 8'd0)
                TimeLeft <= TimeLeft - 8'd1;

            if (restart) begin
                Score1 <= 4'd0;
                Score2 <= 4'd0;
            end else if (goal) begin
                if (goal_l) begin
                    if (Score2 != 4'd15) Score2 <= Score2 + 4'd1;
                end else begin
                    if (Score1 != 4'd15) Score1 <= Score1 + 4'd1;
                end
            end

            if (restart)
                Winner <= 2'b00;
            else if (state_next == S_GAME_OVER && state_reg != S_GAME_OVER)
                Winner <= (Score1 > Score2) ? 2'b01 : (Score2 > Score1) ? 2'b10 : 2'b11;
        end
    end

    assign State = state_reg;

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match sequencer for the head-soccer game. It owns when the ball physics block runs, detects goals from the ball's reported position, and keeps score and the match clock. It sits between the ball block (drives its `Reset`, reads `BallX`/`BallY`/`BallS`) and the HUD/sprite logic (scores, time, state, winner). Character movers use `Freeze`.

## Interface
Parameters:
- `KICKOFF_FRAMES`, 120: frames held in KICKOFF before play.
- `GOAL_FRAMES`, 90: frames held in GOAL (celebration).
- `FRAMES_PER_SEC`, 60: `frame_clk` ticks per match second.
- `MATCH_SECONDS`, 90: match length in seconds; valid range 1..255.
- `WIN_SCORE`, 5: score that ends the match; valid range 1..15.
- `GOAL_X_L`, 8: player-2 goal when `BallX <= GOAL_X_L`.
- `GOAL_X_R`, 631: player-1 goal when `BallX + BallS >= GOAL_X_R`.
- `GOAL_Y_TOP`, 360: goal mouth; both goal tests also require `BallY >= GOAL_Y_TOP`.

Ports:
- `frame_clk`, in, 1: the only clock, one tick per video frame.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Start`, in, 1: start key, level; only its rising edge is used.
- `BallX`, in, 10: ball position from the ball block.
- `BallY`, in, 10: ball position from the ball block.
- `BallS`, in, 10: ball size from the ball block.
- `BallRst`, out, 1: active-high; drives the ball block's `Reset`.
- `Freeze`, out, 1: high means characters must not move.
- `Score1`, out, 4: player 1 score.
- `Score2`, out, 4: player 2 score.
- `TimeLeft`, out, 8: remaining match seconds.
- `State`, out, 3: IDLE=0, KICKOFF=1, PLAY=2, GOAL=3, GAME_OVER=4.
- `Winner`, out, 2: 00 none, 01 P1, 10 P2, 11 draw.
- `GoalFlash`, out, 1: high throughout GOAL.

## Operation
- Start edge detection:
  - `Start` is registered once.
  - `start_rise = Start & ~Start_q`.
- Shared down-counter `hold_cnt`:
  - On entry to KICKOFF it loads `KICKOFF_FRAMES-1`; on entry to GOAL it loads `GOAL_FRAMES-1`.
  - It decrements each cycle in those states.
  - The exit fires on the cycle it reads 0, so each state lasts exactly N cycles.
- Second counter `sub_cnt`:
  - Counts only in PLAY, from 0 to `FRAMES_PER_SEC-1`.
  - On wrap, `TimeLeft` decrements by 1.
  - It holds its value in all other states and is cleared on match restart.
- Goal detect, evaluated only in PLAY, combinationally from the current ball inputs:
  - `goal_l` (P2 scores) and `goal_r` (P1 scores) as defined by the parameters.
  - If both are true, `goal_l` wins.
  - Comparisons are done in 11 bits, so `BallX+BallS` does not wrap.
- Transitions:
  - IDLE: on `start_rise`, go to KICKOFF.
  - KICKOFF: when `hold_cnt==0`, go to PLAY.
  - PLAY, goal detected: increment the scorer's score (saturating at 15) and go to GOAL. This takes priority over timeout on the same cycle.
  - PLAY, second wrap with `TimeLeft==1`: `TimeLeft` becomes 0 and the state goes to GAME_OVER.
  - GOAL at `hold_cnt==0`:
    - If `Score1>=WIN_SCORE`, `Score2>=WIN_SCORE`, or `TimeLeft==0`, go to GAME_OVER.
    - Otherwise go to KICKOFF.
  - GAME_OVER: on `start_rise`, clear scores, reload `TimeLeft=MATCH_SECONDS`, clear `sub_cnt` and `Winner`, and go to KICKOFF.
- Winner, loaded on the edge that enters GAME_OVER:
  - 01 if `Score1>Score2`.
  - 10 if `Score2>Score1`.
  - 11 if the scores are equal.
- Outputs:
  - `BallRst = (State != PLAY)`, so the ball is re-centred with zero velocity whenever not in play.
  - `Freeze = (State != PLAY)`.
  - `GoalFlash = (State == GOAL)`.
  - These are registered from next-state, so they change on the same edge as `State`.
- `Start` is ignored in KICKOFF, PLAY and GOAL.

## Timing
- Reset (`Reset_n` low, asynchronous) puts every output in this state:

| Output | Reset value |
|---|---|
| `State` | IDLE |
| `BallRst` | 1 |
| `Freeze` | 1 |
| `Score1`, `Score2` | 0 |
| `TimeLeft` | `MATCH_SECONDS` |
| `Winner` | 00 |
| `GoalFlash` | 0 |

  `Start_q`, `hold_cnt` and `sub_cnt` reset to 0.
- Reset release is synchronous to `frame_clk`.
- Reset asserted mid-match aborts immediately, with no score retained.
- Latencies:
  - `start_rise` to `State==KICKOFF`: 1 edge after `Start` is sampled high.
  - Goal condition to score increment and `State==GOAL`: 1 edge.
  - First PLAY cycle: `BallRst` falls and the ball block starts from centre. The ball inputs still show centre on this cycle, so no spurious goal fires.
  - Holding `Start` high produces one start only; a new low-to-high transition is needed for another.

## Test plan
Simulation parameters for all scenarios: `KICKOFF_FRAMES=4`, `GOAL_FRAMES=3`, `FRAMES_PER_SEC=2`, `MATCH_SECONDS=5`, `WIN_SCORE=3`.

- Reset and start: release reset, then pulse `Start` at cycle 2.
  - Expect IDLE with `BallRst=1` and `TimeLeft=5` before the pulse.
  - Expect KICKOFF at edge 3 and PLAY at edge 7, with `BallRst` falling at that same edge.
- P1 goal: in PLAY drive `BallX=620`, `BallS=16`, `BallY=400`.
  - Expect `Score1=1`, GOAL and `GoalFlash=1` next edge.
  - After 3 cycles expect KICKOFF, then after 4 cycles PLAY.
  - `Score2` stays 0.
- Off-target: `BallX=0`, `BallY=300`, which is above the goal mouth.
  - Expect no score change.
  - Then move to `BallY=360`: expect `Score2` to increment.
- Timeout: hold the ball at centre for 10 PLAY cycles.
  - Expect `TimeLeft` to step 5, 4, 3, 2, 1, 0 every 2 cycles.
  - Expect `State=GAME_OVER` on the edge where it reaches 0, with `Winner=11` at 0-0.
- Goal at the final second: a goal on the same cycle as the last wrap.
  - Expect the score to increment, `TimeLeft=0` and GOAL.
  - After 3 cycles expect GAME_OVER with the correct `Winner`.
- Win and restart, plus async reset:
  - Reach `Score1=3`: expect GAME_OVER after GOAL with `Winner=01`.
  - Pulse `Start`: expect scores 0, `TimeLeft=5`, `Winner=00` and KICKOFF.
  - Assert `Reset_n` low mid-PLAY between clock edges: expect IDLE and all reset values immediately.
